alu_master: RTL and testbench

ALU_MASTER -- requirements
Module: alu_master

---
 rtl/alu_master.sv | 161 ++++++++++++++++
 tb/tb_alu_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_master.sv
// Command-to-ALU sequencer: accepts one command, drives the selected ALU bank,
// waits RESULT_WAIT cycles, clears any ALU interrupt and returns one response.
module alu_master #(
    parameter int unsigned RESULT_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_mode_a,
    input  logic       cmd_mode_b,
    input  logic [1:0] cmd_op_a,
    input  logic [1:0] cmd_op_b,
    input  logic [7:0] cmd_in_a,
    input  logic [7:0] cmd_in_b,
    output logic       alu_enable,
    output logic       alu_enable_a,
    output logic       alu_enable_b,
    output logic [1:0] alu_op_a,
    output logic [1:0] alu_op_b,
    output logic [7:0] alu_in_a,
    output logic [7:0] alu_in_b,
    output logic       alu_irq_clr,
    input  logic       alu_irq,
    input  logic [7:0] alu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_irq,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CLEAR, S_RESP} state_t;

    typedef struct packed {
        logic       mode_a;
        logic       mode_b;
        logic [1:0] op_a;
        logic [1:0] op_b;
        logic [7:0] in_a;
        logic [7:0] in_b;
    } cmd_t;

    localparam logic [3:0] WAIT_LOAD = 4'(RESULT_WAIT - 1);

    state_t     state, state_nxt;
    cmd_t       cmd_q, cmd_in, cmd_src;
    logic [3:0] cnt, cnt_nxt;
    logic       irq_flag, irq_flag_nxt;
    logic [7:0] rsp_data_nxt;
    logic       rsp_irq_nxt, rsp_err_nxt;
    logic       accept, single_mode, irq_seen, drive_nxt;

    assign cmd_in      = {cmd_mode_a, cmd_mode_b, cmd_op_a, cmd_op_b, cmd_in_a, cmd_in_b};
    assign accept      = (state == S_IDLE) && cmd_valid;
    assign single_mode = cmd_mode_a ^ cmd_mode_b;
    assign irq_seen    = irq_flag | alu_irq;
    assign drive_nxt   = (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
    // Outputs are registered from the next state, so on the accept edge the
    // ALU drive has to come straight from the command inputs.
    assign cmd_src     = (state == S_IDLE) ? cmd_in : cmd_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_nxt    = state;
        cnt_nxt      = cnt;
        irq_flag_nxt = irq_flag;
        rsp_data_nxt = rsp_data;
        rsp_irq_nxt  = rsp_irq;
        rsp_err_nxt  = rsp_err;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    irq_flag_nxt = 1'b0;
                    if (single_mode) begin
                        state_nxt = S_ISSUE;
                    end else begin
                        state_nxt    = S_RESP;
                        rsp_data_nxt = 8'h00;
                        rsp_irq_nxt  = 1'b0;
                        rsp_err_nxt  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                irq_flag_nxt = irq_seen;
                cnt_nxt      = WAIT_LOAD;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                irq_flag_nxt = irq_seen;
                if (cnt == 4'd0) begin
                    rsp_data_nxt = alu_out;
                    rsp_irq_nxt  = irq_seen;
                    rsp_err_nxt  = 1'b0;
                    state_nxt    = irq_seen ? S_CLEAR : S_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_CLEAR: state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt    = S_IDLE;
                    rsp_data_nxt = 8'h00;
                    rsp_irq_nxt  = 1'b0;
                    rsp_err_nxt  = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            irq_flag     <= 1'b0;
            cmd_q        <= '0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            alu_enable   <= 1'b0;
            alu_enable_a <= 1'b0;
            alu_enable_b <= 1'b0;
            alu_op_a     <= 2'd0;
            alu_op_b     <= 2'd0;
            alu_in_a     <= 8'h00;
            alu_in_b     <= 8'h00;
            alu_irq_clr  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= 8'h00;
            rsp_irq      <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            irq_flag     <= irq_flag_nxt;
            if (accept) cmd_q <= cmd_in;
            cmd_ready    <= (state_nxt == S_IDLE);
            busy         <= (state_nxt != S_IDLE);
            alu_enable   <= drive_nxt;
            alu_enable_a <= drive_nxt & cmd_src.mode_a;
            alu_enable_b <= drive_nxt & cmd_src.mode_b;
            alu_op_a     <= drive_nxt ? cmd_src.op_a : 2'd0;
            alu_op_b     <= drive_nxt ? cmd_src.op_b : 2'd0;
            alu_in_a     <= drive_nxt ? cmd_src.in_a : 8'h00;
            alu_in_b     <= drive_nxt ? cmd_src.in_b : 8'h00;
            alu_irq_clr  <= (state_nxt == S_CLEAR);
            rsp_valid    <= (state_nxt == S_RESP);
            rsp_data     <= rsp_data_nxt;
            rsp_irq      <= rsp_irq_nxt;
            rsp_err      <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_alu_master.sv
// Directed bench for alu_master: one task per scenario, inputs driven and
// outputs sampled on the falling clock edge.
module tb_alu_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic       cmd_mode_a, cmd_mode_b;
    logic [1:0] cmd_op_a, cmd_op_b;
    logic [7:0] cmd_in_a, cmd_in_b;
    logic       alu_enable, alu_enable_a, alu_enable_b;
    logic [1:0] alu_op_a, alu_op_b;
    logic [7:0] alu_in_a, alu_in_b;
    logic       alu_irq_clr, alu_irq;
    logic [7:0] alu_out;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_irq, rsp_err, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_master #(.RESULT_WAIT(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode_a(cmd_mode_a), .cmd_mode_b(cmd_mode_b),
        .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b),
        .cmd_in_a(cmd_in_a), .cmd_in_b(cmd_in_b),
        .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_irq_clr(alu_irq_clr), .alu_irq(alu_irq), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_irq(rsp_irq), .rsp_err(rsp_err),
        .busy(busy)
    );

    // Issues one command from an IDLE falling edge and returns at the first
    // falling edge where rsp_valid is seen. lat counts edges after the accept edge.
    task automatic run_cmd(input logic ma, input logic mb, input logic [1:0] oa, input logic [1:0] ob,
                           input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] av,
                           input logic irq_acc, input logic [7:0] irq_mask,
                           output int lat, output int en, output int clr, output int ovl,
                           output logic [21:0] snap);
        cmd_mode_a = ma; cmd_mode_b = mb; cmd_op_a = oa; cmd_op_b = ob;
        cmd_in_a = ia; cmd_in_b = ib; alu_out = av; alu_irq = irq_acc;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0; en = 0; clr = 0; ovl = 0;
        snap = {alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b};
        while (rsp_valid !== 1'b1 && lat < 40) begin
            alu_irq = (lat < 8) ? irq_mask[3'(lat)] : 1'b0;
            if (alu_enable) en++;
            if (alu_irq_clr) clr++;
            if (alu_enable && alu_irq_clr) ovl++;
            @(negedge clk);
            lat++;
        end
        alu_irq = 1'b0;
        total++; if (lat >= 40) begin bad++; $display("FAIL rsp_timeout: waited=%0d limit=40", lat); end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode_a = 1'b0; cmd_mode_b = 1'b0;
        cmd_op_a = 2'd0; cmd_op_b = 2'd0; cmd_in_a = 8'h00; cmd_in_b = 8'h00;
        alu_irq = 1'b0; alu_out = 8'h00; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got=%b exp=1", cmd_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b exp=0", busy); end
        total++; if ({alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr} !== 4'b0) begin bad++;
            $display("FAIL reset_alu_ctl: got=%b exp=0000", {alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr}); end
        total++; if ({alu_op_a, alu_op_b, alu_in_a, alu_in_b} !== 20'h0) begin bad++;
            $display("FAIL reset_alu_fields: got=%h exp=0", {alu_op_a, alu_op_b, alu_in_a, alu_in_b}); end
        total++; if ({rsp_valid, rsp_irq, rsp_err, rsp_data} !== 11'h0) begin bad++;
            $display("FAIL reset_rsp: got=%h exp=0", {rsp_valid, rsp_irq, rsp_err, rsp_data}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal();
        int lat, en, clr, ovl;
        logic [21:0] snap;
        rsp_ready = 1'b1;
        run_cmd(1'b1, 1'b0, 2'd0, 2'd0, 8'h12, 8'h34, 8'h46, 1'b0, 8'h00, lat, en, clr, ovl, snap);
        total++; if (lat != 3) begin bad++; $display("FAIL norm_latency: got=%0d exp=3", lat); end
        total++; if (en != 3) begin bad++; $display("FAIL norm_enable_cycles: got=%0d exp=3", en); end
        total++; if (clr != 0) begin bad++; $display("FAIL norm_irq_clr: got=%0d exp=0", clr); end
        total++; if (snap !== {1'b1, 1'b0, 2'd0, 2'd0, 8'h12, 8'h34}) begin bad++;
            $display("FAIL norm_alu_drive: got=%h exp=%h", snap, {1'b1, 1'b0, 2'd0, 2'd0, 8'h12, 8'h34}); end
        total++; if ({rsp_data, rsp_irq, rsp_err} !== {8'h46, 1'b0, 1'b0}) begin bad++;
            $display("FAIL norm_payload: got=%h/%b/%b exp=46/0/0", rsp_data, rsp_irq, rsp_err); end
        total++; if ({busy, cmd_ready} !== 2'b10) begin bad++; $display("FAIL norm_resp_busy: got=%b exp=10", {busy, cmd_ready}); end
        @(negedge clk);
        total++; if ({rsp_valid, cmd_ready, busy, alu_enable} !== 4'b0100) begin bad++;
            $display("FAIL norm_back_idle: got=%b exp=0100", {rsp_valid, cmd_ready, busy, alu_enable}); end
        total++; if ({alu_in_a, alu_in_b} !== 16'h0) begin bad++; $display("FAIL norm_idle_fields: got=%h exp=0", {alu_in_a, alu_in_b}); end
    endtask

    task automatic test_irq();
        int lat, en, clr, ovl;
        logic [21:0] snap;
        rsp_ready = 1'b1;
        // irq only on the first WAIT cycle: flag must be sticky
        run_cmd(1'b1, 1'b0, 2'd0, 2'd0, 8'h12, 8'h34, 8'h46, 1'b0, 8'b0000_0010, lat, en, clr, ovl, snap);
        total++; if (lat != 4) begin bad++; $display("FAIL irq_latency: got=%0d exp=4", lat); end
        total++; if (en != 3 || clr != 1 || ovl != 0) begin bad++;
            $display("FAIL irq_clear_pulse: en=%0d clr=%0d overlap=%0d exp 3/1/0", en, clr, ovl); end
        total++; if ({rsp_data, rsp_irq, rsp_err} !== {8'h46, 1'b1, 1'b0}) begin bad++;
            $display("FAIL irq_payload: got=%h/%b/%b exp=46/1/0", rsp_data, rsp_irq, rsp_err); end
        @(negedge clk);
        // irq only on the last WAIT cycle
        run_cmd(1'b1, 1'b0, 2'd1, 2'd0, 8'h01, 8'h02, 8'h9C, 1'b0, 8'b0000_0100, lat, en, clr, ovl, snap);
        total++; if (lat != 4 || clr != 1) begin bad++; $display("FAIL irq_last_wait: lat=%0d clr=%0d exp 4/1", lat, clr); end
        total++; if ({rsp_data, rsp_irq} !== {8'h9C, 1'b1}) begin bad++;
            $display("FAIL irq_last_payload: got=%h/%b exp=9c/1", rsp_data, rsp_irq); end
        @(negedge clk);
        // irq present only in IDLE during the accept cycle: ignored
        run_cmd(1'b1, 1'b0, 2'd0, 2'd0, 8'h05, 8'h06, 8'h0B, 1'b1, 8'h00, lat, en, clr, ovl, snap);
        total++; if (lat != 3 || clr != 0 || rsp_irq !== 1'b0) begin bad++;
            $display("FAIL irq_idle_ignored: lat=%0d clr=%0d rsp_irq=%b exp 3/0/0", lat, clr, rsp_irq); end
        @(negedge clk);
    endtask

    task automatic test_error();
        int lat, en, clr, ovl;
        logic [21:0] snap;
        rsp_ready = 1'b1;
        run_cmd(1'b1, 1'b1, 2'd2, 2'd3, 8'h12, 8'h34, 8'hFF, 1'b0, 8'h00, lat, en, clr, ovl, snap);
        total++; if (lat != 0 || en != 0 || snap !== 22'h0) begin bad++;
            $display("FAIL err_both_no_alu: lat=%0d en=%0d drive=%h exp 0/0/0", lat, en, snap); end
        total++; if ({rsp_data, rsp_irq, rsp_err} !== {8'h00, 1'b0, 1'b1}) begin bad++;
            $display("FAIL err_both_payload: got=%h/%b/%b exp=00/0/1", rsp_data, rsp_irq, rsp_err); end
        @(negedge clk);
        run_cmd(1'b0, 1'b0, 2'd1, 2'd1, 8'hAA, 8'hBB, 8'h77, 1'b0, 8'h00, lat, en, clr, ovl, snap);
        total++; if (lat != 0 || en != 0 || {rsp_data, rsp_err} !== {8'h00, 1'b1}) begin bad++;
            $display("FAIL err_none: lat=%0d en=%0d data=%h err=%b exp 0/0/00/1", lat, en, rsp_data, rsp_err); end
        @(negedge clk);
    endtask

    task automatic test_bank_b();
        int lat, en, clr, ovl;
        logic [21:0] snap;
        rsp_ready = 1'b1;
        run_cmd(1'b0, 1'b1, 2'd1, 2'd3, 8'hAA, 8'h55, 8'hC3, 1'b0, 8'h00, lat, en, clr, ovl, snap);
        total++; if (snap !== {1'b0, 1'b1, 2'd1, 2'd3, 8'hAA, 8'h55}) begin bad++;
            $display("FAIL bank_b_drive: got=%h exp=%h", snap, {1'b0, 1'b1, 2'd1, 2'd3, 8'hAA, 8'h55}); end
        total++; if (lat != 3 || rsp_data !== 8'hC3) begin bad++;
            $display("FAIL bank_b_result: lat=%0d data=%h exp 3/c3", lat, rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat, en, clr, ovl;
        logic [21:0] snap;
        rsp_ready = 1'b0;
        run_cmd(1'b1, 1'b0, 2'd2, 2'd0, 8'h01, 8'h02, 8'h5A, 1'b0, 8'h00, lat, en, clr, ovl, snap);
        cmd_mode_a = 1'b0; cmd_mode_b = 1'b1; cmd_in_b = 8'hEE; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if ({rsp_valid, rsp_data, rsp_irq, rsp_err, cmd_ready} !== {1'b1, 8'h5A, 1'b0, 1'b0, 1'b0}) begin bad++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h irq=%b err=%b ready=%b exp 1/5a/0/0/0",
                         i, rsp_valid, rsp_data, rsp_irq, rsp_err, cmd_ready); end
            @(negedge clk);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        total++; if ({rsp_valid, busy, cmd_ready, alu_enable} !== 4'b0010) begin bad++;
            $display("FAIL stall_no_queue: got=%b exp=0010", {rsp_valid, busy, cmd_ready, alu_enable}); end
    endtask

    task automatic test_reset_mid();
        int lat, en, clr, ovl, seen;
        logic [21:0] snap;
        rsp_ready = 1'b1;
        cmd_mode_a = 1'b1; cmd_mode_b = 1'b0; cmd_op_a = 2'd3; cmd_in_a = 8'h21; cmd_in_b = 8'h43;
        alu_out = 8'h64; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        alu_irq = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; alu_irq = 1'b0;
        total++; if ({alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr, alu_op_a, alu_in_a, alu_in_b} !== 22'h0) begin bad++;
            $display("FAIL rst_mid_alu: got=%h exp=0", {alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr, alu_op_a, alu_in_a, alu_in_b}); end
        total++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin bad++;
            $display("FAIL rst_mid_ctl: got=%b exp=010", {rsp_valid, cmd_ready, busy}); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid || alu_irq_clr || alu_enable) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_aborted: activity_cycles=%0d exp=0", seen); end
        run_cmd(1'b1, 1'b0, 2'd0, 2'd0, 8'h10, 8'h2C, 8'h3C, 1'b0, 8'h00, lat, en, clr, ovl, snap);
        total++; if (lat != 3 || {rsp_data, rsp_irq, rsp_err} !== {8'h3C, 1'b0, 1'b0}) begin bad++;
            $display("FAIL rst_mid_recover: lat=%0d data=%h irq=%b err=%b exp 3/3c/0/0", lat, rsp_data, rsp_irq, rsp_err); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n_acc, n_rsp, ovl;
        logic pend;
        logic [7:0] got [2];
        got[0] = 8'h00; got[1] = 8'h00;
        n_acc = 0; n_rsp = 0; ovl = 0; pend = 1'b0;
        rsp_ready = 1'b1;
        cmd_mode_a = 1'b1; cmd_mode_b = 1'b0; cmd_op_a = 2'd1; cmd_in_a = 8'h01; cmd_in_b = 8'h02;
        cmd_valid = 1'b1;
        for (int c = 0; c < 40 && n_rsp < 2; c++) begin
            // ALU stand-in: bank A returns A1, bank B returns B2
            alu_out = alu_enable_b ? 8'hB2 : 8'hA1;
            if (alu_enable_a && alu_enable_b) ovl++;
            if (rsp_valid) begin got[n_rsp] = rsp_data; n_rsp++; end
            if (pend) begin
                if (n_acc == 1) begin cmd_mode_a = 1'b0; cmd_mode_b = 1'b1; cmd_op_b = 2'd2; cmd_in_b = 8'h77; end
                else cmd_valid = 1'b0;
                pend = 1'b0;
            end
            if (cmd_ready && cmd_valid) begin n_acc++; pend = 1'b1; end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        total++; if (n_acc != 2 || n_rsp != 2) begin bad++; $display("FAIL b2b_counts: acc=%0d rsp=%0d exp 2/2", n_acc, n_rsp); end
        total++; if (got[0] !== 8'hA1 || got[1] !== 8'hB2) begin bad++;
            $display("FAIL b2b_data: got=%h,%h exp=a1,b2", got[0], got[1]); end
        total++; if (ovl != 0) begin bad++; $display("FAIL b2b_overlap: cycles=%0d exp=0", ovl); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal();
        test_irq();
        test_error();
        test_bank_b();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
